// File: rtl/uart_pkg.sv
// Shared UART constants for the RX path.
package uart_pkg;
    localparam int UART_DATA_W = 8;
    localparam int CLK_HZ      = 50_000_000;
    localparam int BAUD        = 115200;
    localparam int BAUD_DIV    = 434;
endpackage

// File: rtl/fifo_mem.sv
// Register-array storage for the RX FIFO: one write port, one async read port.
module fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                     aclk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Kept in its own module so a BRAM/LUTRAM macro can replace it later.
    always_ff @(posedge aclk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind the UART RX controller,
// with fill level, almost-full and sticky overrun reporting.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int DATA_W    = UART_DATA_W
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [DATA_W-1:0]        s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [DATA_W-1:0]        m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full,
    output logic                     overrun
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AF_LVL = (AW + 1)'(AF_THRESH);

    logic [AW:0]       wr_ptr, rd_ptr;
    logic [AW:0]       level_nxt;
    logic [DATA_W-1:0] rd_data;
    logic              full, empty, push, pop;

    // Flags come only from registered pointers, so m_ready never reaches s_ready.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign s_ready = !full;
    assign m_valid = !empty;
    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;
    assign m_data  = m_valid ? rd_data : '0;

    always_comb begin
        level_nxt = level;
        if (flush)             level_nxt = '0;
        else if (push && !pop) level_nxt = level + 1'b1;
        else if (pop && !push) level_nxt = level - 1'b1;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            almost_full <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            level       <= level_nxt;
            almost_full <= (level_nxt >= AF_LVL);
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                overrun <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (s_valid && full) overrun <= 1'b1;
            end
        end
    end

    fifo_mem #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_mem (
        .aclk  (aclk),
        .we    (push && !flush),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (s_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_data)
    );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized + directed bench for uart_rx_fifo against a queue-based model.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic       flush = 1'b0;
    logic [4:0] level;
    logic       almost_full;
    logic       overrun;

    int vectors = 0;
    int miscompares = 0;

    uart_rx_fifo #(.DEPTH(DEPTH), .AF_THRESH(AF), .DATA_W(8)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .flush(flush), .level(level), .almost_full(almost_full), .overrun(overrun)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a plain byte queue plus a sticky overrun bit.
    logic [7:0] q[$];
    bit         m_ovr;
    bit         m_full;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            q.delete();
            m_ovr = 0;
        end else if (flush) begin
            q.delete();
            m_ovr = 0;
        end else begin
            m_full = (q.size() == DEPTH);
            if (s_valid && m_full) m_ovr = 1;
            if (m_ready && q.size() > 0) void'(q.pop_front());
            if (s_valid && !m_full) q.push_back(s_data);
        end
    end

    always @(negedge aclk) begin
        chk("s_ready", s_ready, q.size() < DEPTH);
        chk("m_valid", m_valid, q.size() > 0);
        chk("m_data", m_data, q.size() > 0 ? q[0] : 8'h00);
        chk("level", level, q.size());
        chk("almost_full", almost_full, q.size() >= AF);
        chk("overrun", overrun, m_ovr);
    end

    // One call = one clock cycle with the given inputs; returns 1 time unit after the edge.
    task automatic drive(input bit v, input logic [7:0] d, input bit r, input bit f);
        s_valid = v; s_data = d; m_ready = r; flush = f;
        @(posedge aclk);
        #1;
    endtask

    task automatic idle();
        drive(0, 8'h00, 0, 0);
    endtask

    initial begin
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_level", level, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_ready", s_ready, 1);
        aresetn = 1'b1;
        idle();

        // 1: single byte, 1-cycle latency
        drive(1, 8'hA5, 0, 0);
        chk("t1_m_valid", m_valid, 1);
        chk("t1_m_data", m_data, 8'hA5);
        chk("t1_level", level, 1);
        drive(0, 8'h00, 1, 0);
        chk("t1_empty", m_valid, 0);

        // 2: fill to full, almost_full from 12, drain in order
        for (int i = 0; i < 16; i++) begin
            drive(1, 8'(i), 0, 0);
            chk("t2_level", level, i + 1);
            chk("t2_af", almost_full, (i + 1) >= 12);
        end
        chk("t2_s_ready", s_ready, 0);
        idle();
        for (int i = 0; i < 16; i++) begin
            chk("t2_drain", m_data, i);
            drive(0, 8'h00, 1, 0);
        end
        chk("t2_empty", m_valid, 0);

        // 3: overrun while full; push only after the pop
        for (int i = 0; i < 16; i++) drive(1, 8'($urandom), 0, 0);
        drive(1, 8'h55, 1, 0);
        chk("t3_overrun", overrun, 1);
        chk("t3_level_pop", level, 15);
        drive(1, 8'h55, 0, 0);
        chk("t3_level_refill", level, 16);
        drive(1, 8'h55, 0, 0);
        chk("t3_level_held", level, 16);
        idle();

        // 4: steady push/pop at level 5 across pointer wrap
        drive(0, 8'h00, 0, 1);
        for (int i = 0; i < 5; i++) drive(1, 8'($urandom), 0, 0);
        for (int i = 0; i < 40; i++) begin
            drive(1, 8'($urandom), 1, 0);
            chk("t4_level", level, 5);
        end
        idle();

        // 5: flush with a concurrent push discards everything
        drive(0, 8'h00, 0, 1);
        for (int i = 0; i < 17; i++) drive(1, 8'($urandom), 0, 0);
        for (int i = 0; i < 7; i++) drive(0, 8'h00, 1, 0);
        chk("t5_level9", level, 9);
        chk("t5_ovr_set", overrun, 1);
        drive(1, 8'h77, 0, 1);
        chk("t5_level0", level, 0);
        chk("t5_m_valid", m_valid, 0);
        chk("t5_ovr_clr", overrun, 0);
        idle();
        chk("t5_discard", m_valid, 0);

        // 6: async reset mid-cycle
        for (int i = 0; i < 7; i++) drive(1, 8'($urandom), 0, 0);
        #3 aresetn = 1'b0;
        #1;
        chk("t6_m_valid", m_valid, 0);
        chk("t6_level", level, 0);
        chk("t6_af", almost_full, 0);
        @(posedge aclk);
        #1 aresetn = 1'b1;
        drive(1, 8'h3C, 0, 0);
        chk("t6_readback", m_data, 8'h3C);
        idle();

        // Random traffic with occasional flushes
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 31) == 0);
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 3) != 0, 1'b0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
